// File: rtl/vga_axil_arbiter.sv
// rtl/vga_axil_arbiter.sv - round-robin AXI4-Lite arbiter, N masters onto one VGA register slave
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   m_aw*/m_w*/m_b*           per-master write channels, slice i belongs to master i
//   m_ar*/m_r*                per-master read channels, slice i belongs to master i
//   s_aw*/s_w*/s_b*           slave write channels
//   s_ar*/s_r*                slave read channels
// The read and write paths each hold one outstanding transaction and arbitrate independently.
module vga_axil_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [N_MASTERS-1:0]        m_awvalid,
    output logic [N_MASTERS-1:0]        m_awready,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0] m_wstrb,
    input  logic [N_MASTERS-1:0]        m_wvalid,
    output logic [N_MASTERS-1:0]        m_wready,
    output logic [N_MASTERS*2-1:0]      m_bresp,
    output logic [N_MASTERS-1:0]        m_bvalid,
    input  logic [N_MASTERS-1:0]        m_bready,
    input  logic [N_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [N_MASTERS-1:0]        m_arvalid,
    output logic [N_MASTERS-1:0]        m_arready,
    output logic [N_MASTERS*DATA_W-1:0] m_rdata,
    output logic [N_MASTERS*2-1:0]      m_rresp,
    output logic [N_MASTERS-1:0]        m_rvalid,
    input  logic [N_MASTERS-1:0]        m_rready,
    output logic [ADDR_W-1:0]           s_awaddr,
    output logic                        s_awvalid,
    input  logic                        s_awready,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [STRB_W-1:0]           s_wstrb,
    output logic                        s_wvalid,
    input  logic                        s_wready,
    input  logic [1:0]                  s_bresp,
    input  logic                        s_bvalid,
    output logic                        s_bready,
    output logic [ADDR_W-1:0]           s_araddr,
    output logic                        s_arvalid,
    input  logic                        s_arready,
    input  logic [DATA_W-1:0]           s_rdata,
    input  logic [1:0]                  s_rresp,
    input  logic                        s_rvalid,
    output logic                        s_rready
);

    localparam int GW = $clog2(N_MASTERS);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rstate_t;

    wstate_t wstate, wstate_nx;
    rstate_t rstate, rstate_nx;
    logic [GW-1:0] wgnt, wptr, rgnt, rptr;
    logic          aw_done, w_done;

    // First requester at or after ptr, searching circularly.
    function automatic logic [GW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                              input logic [GW-1:0] ptr);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = (int'(ptr) + k) % N_MASTERS;
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        return (g == GW'(N_MASTERS - 1)) ? '0 : g + 1'b1;
    endfunction

    // Handshakes seen by the slave; a finished channel has its valid masked off.
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
    assign aw_fire = (wstate == W_XFER) && m_awvalid[wgnt] && !aw_done && s_awready;
    assign w_fire  = (wstate == W_XFER) && m_wvalid[wgnt]  && !w_done  && s_wready;
    assign b_fire  = (wstate == W_RESP) && s_bvalid && m_bready[wgnt];
    assign ar_fire = (rstate == R_ADDR) && m_arvalid[rgnt] && s_arready;
    assign r_fire  = (rstate == R_RESP) && s_rvalid && m_rready[rgnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_IDLE;
            wgnt    <= '0;
            wptr    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            wstate <= wstate_nx;
            if (wstate == W_IDLE && |m_awvalid)
                wgnt <= rr_pick(m_awvalid, wptr);
            if (aw_fire)
                aw_done <= 1'b1;
            if (w_fire)
                w_done <= 1'b1;
            if (b_fire) begin
                wptr    <= next_ptr(wgnt);
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        wstate_nx = wstate;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (|m_awvalid)
                    wstate_nx = W_XFER;
            end
            W_XFER: begin
                s_awaddr        = m_awaddr[int'(wgnt)*ADDR_W +: ADDR_W];
                s_awvalid       = m_awvalid[wgnt] && !aw_done;
                m_awready[wgnt] = s_awready && !aw_done;
                s_wdata         = m_wdata[int'(wgnt)*DATA_W +: DATA_W];
                s_wstrb         = m_wstrb[int'(wgnt)*STRB_W +: STRB_W];
                s_wvalid        = m_wvalid[wgnt] && !w_done;
                m_wready[wgnt]  = s_wready && !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire))
                    wstate_nx = W_RESP;
            end
            W_RESP: begin
                m_bresp[int'(wgnt)*2 +: 2] = s_bresp;
                m_bvalid[wgnt]             = s_bvalid;
                s_bready                   = m_bready[wgnt];
                if (b_fire)
                    wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rgnt   <= '0;
            rptr   <= '0;
        end else begin
            rstate <= rstate_nx;
            if (rstate == R_IDLE && |m_arvalid)
                rgnt <= rr_pick(m_arvalid, rptr);
            if (r_fire)
                rptr <= next_ptr(rgnt);
        end
    end

    always_comb begin
        rstate_nx = rstate;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (|m_arvalid)
                    rstate_nx = R_ADDR;
            end
            R_ADDR: begin
                s_araddr        = m_araddr[int'(rgnt)*ADDR_W +: ADDR_W];
                s_arvalid       = m_arvalid[rgnt];
                m_arready[rgnt] = s_arready;
                if (ar_fire)
                    rstate_nx = R_RESP;
            end
            R_RESP: begin
                m_rdata[int'(rgnt)*DATA_W +: DATA_W] = s_rdata;
                m_rresp[int'(rgnt)*2 +: 2]           = s_rresp;
                m_rvalid[rgnt]                       = s_rvalid;
                s_rready                             = m_rready[rgnt];
                if (r_fire)
                    rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

endmodule
